// File: rtl/counter_event_collector_if.sv
// Register bus, interrupt and event stream between the collector and the engine.
interface counter_event_collector_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        irq;
    logic        ev_valid;
    logic [2:0]  ev_id;
    logic        ev_ready;

    // Host / engine side
    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata, ev_ready,
        input  reg_rdata, irq, ev_valid, ev_id
    );

    // Collector side
    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata, ev_ready,
        output reg_rdata, irq, ev_valid, ev_id
    );
endinterface

// File: rtl/counter_event_collector.sv
// Counter event collector: auto-acks counter terminal flags, keeps sticky
// maskable status with an interrupt, and queues event IDs into a small FIFO.
// The register map is laid out for five counter channels.
module counter_event_collector #(
    parameter int NUM_CH      = 5,
    parameter int ACK_TIMEOUT = 15,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              sysclk,
    input  logic              foo_card_n,
    input  logic [NUM_CH-1:0] cwm_in,
    output logic [NUM_CH-1:0] zz1pb_out,
    input  logic              debct_pull,
    input  logic              wdfilecardA2P,
    counter_event_collector_if.slave bus
);
    localparam int NUM_EV = NUM_CH + 2;
    localparam int SW     = 2 * NUM_CH + 3;
    localparam int TW     = $clog2(ACK_TIMEOUT + 1);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } ack_state_t;

    logic [NUM_CH-1:0] raise_ch;
    logic [NUM_CH-1:0] tmo_ch;
    logic [NUM_CH-1:0] busy_ch;

    // ---------------- per-channel acknowledge FSMs ----------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ack_state_t      state_reg, state_next;
        logic [TW-1:0]   timer_reg, timer_next;
        logic            zz1pb_l, raise_l, tmo_l;

        // State and timer register; reset aborts any handshake in flight
        always_ff @(posedge sysclk) begin
            if (!foo_card_n) begin
                state_reg <= ST_IDLE;
                timer_reg <= '0;
            end else begin
                state_reg <= state_next;
                timer_reg <= timer_next;
            end
        end

        // Next state: hold ack until flag drops or timer expires, then one re-arm cycle
        always_comb begin
            state_next = state_reg;
            timer_next = timer_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (cwm_in[gi]) begin
                        state_next = ST_ACK;
                        timer_next = '0;
                    end
                end
                ST_ACK: begin
                    timer_next = timer_reg + TW'(1);
                    if (!cwm_in[gi])
                        state_next = ST_WAIT;
                    else if (timer_reg == TW'(ACK_TIMEOUT))
                        state_next = ST_WAIT;
                end
                ST_WAIT: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end

        // Outputs: active-low ack while in ACK, event on flag seen in IDLE
        always_comb begin
            zz1pb_l = 1'b1;
            raise_l = 1'b0;
            tmo_l   = 1'b0;
            case (state_reg)
                ST_IDLE: raise_l = cwm_in[gi];
                ST_ACK: begin
                    zz1pb_l = 1'b0;
                    tmo_l   = cwm_in[gi] && (timer_reg == TW'(ACK_TIMEOUT));
                end
                default: ;
            endcase
        end

        assign zz1pb_out[gi] = zz1pb_l;
        assign raise_ch[gi]  = raise_l;
        assign tmo_ch[gi]    = tmo_l;
        assign busy_ch[gi]   = (state_reg != ST_IDLE);
    end

    // ---------------- event pending / FIFO ----------------
    logic [NUM_EV-1:0] raise, pending_reg, pending_next, push_mask;
    logic              ovf_set, push_en, fifo_full, pop;
    logic [2:0]        push_id;
    logic [2:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    assign raise     = {wdfilecardA2P, debct_pull, raise_ch};
    assign ovf_set   = |(raise & pending_reg);
    assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
    assign pop       = bus.ev_valid && bus.ev_ready;

    // Pick the lowest-index pending event when there is room
    always_comb begin
        push_en = 1'b0;
        push_id = 3'd0;
        for (int i = NUM_EV - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                push_en = 1'b1;
                push_id = 3'(i);
            end
        end
        push_en   = push_en && !fifo_full;
        push_mask = push_en ? (NUM_EV'(1) << push_id) : '0;
        // A duplicate of an already-pending event is dropped (flagged as overflow)
        pending_next = (pending_reg & ~push_mask) | (raise & ~pending_reg);
    end

    // Pending bits, FIFO pointers and level
    always_ff @(posedge sysclk) begin
        if (!foo_card_n) begin
            pending_reg <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push_en) - CW'(pop);
        end
    end

    // FIFO storage; no reset needed since entries are gated by the level
    always_ff @(posedge sysclk) begin
        if (push_en)
            fifo_mem[wr_ptr_reg] <= push_id;
    end

    assign bus.ev_valid = (count_reg != '0);
    assign bus.ev_id    = bus.ev_valid ? fifo_mem[rd_ptr_reg] : 3'd0;

    // ---------------- registers ----------------
    logic [SW-1:0] status_reg, status_set, status_clr, mask_reg;
    logic [31:0]   evcnt_reg, rdata_reg, dbg;
    logic          irq_reg;
    logic          wr_status, wr_mask, wr_evcnt;
    logic          unused_wdata;

    assign wr_status  = bus.reg_wr && (bus.reg_addr == 2'd0);
    assign wr_mask    = bus.reg_wr && (bus.reg_addr == 2'd1);
    assign wr_evcnt   = bus.reg_wr && (bus.reg_addr == 2'd2);
    assign status_set = {tmo_ch, ovf_set, wdfilecardA2P, debct_pull, raise_ch};
    assign status_clr = wr_status ? bus.reg_wdata[SW-1:0] : '0;
    assign unused_wdata = ^bus.reg_wdata[31:SW];

    // Debug view: FIFO level, pending events, per-channel ack busy
    always_comb begin
        dbg               = '0;
        dbg[23:16]        = 8'(count_reg);
        dbg[8 +: NUM_EV]  = pending_reg;
        dbg[0 +: NUM_CH]  = busy_ch;
    end

    // Status (W1C, set wins), mask, event counter, irq and registered read data
    always_ff @(posedge sysclk) begin
        if (!foo_card_n) begin
            status_reg <= '0;
            mask_reg   <= '0;
            evcnt_reg  <= '0;
            irq_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            status_reg <= (status_reg & ~status_clr) | status_set;
            if (wr_mask)
                mask_reg <= bus.reg_wdata[SW-1:0];
            if (wr_evcnt)
                evcnt_reg <= '0;
            else if (push_en)
                evcnt_reg <= evcnt_reg + 32'd1;
            irq_reg <= |(status_reg & mask_reg);
            if (bus.reg_rd) begin
                case (bus.reg_addr)
                    2'd0:    rdata_reg <= 32'(status_reg);
                    2'd1:    rdata_reg <= 32'(mask_reg);
                    2'd2:    rdata_reg <= evcnt_reg;
                    default: rdata_reg <= dbg;
                endcase
            end
        end
    end

    assign bus.irq       = irq_reg;
    assign bus.reg_rdata = rdata_reg;
endmodule

// File: tb/tb_counter_event_collector.sv
// Directed, table-driven bench for counter_event_collector.
module tb_counter_event_collector;
    logic       sysclk = 1'b0;
    logic       foo_card_n;
    logic [4:0] cwm_in;
    logic [4:0] zz1pb_out;
    logic       debct_pull;
    logic       wdfilecardA2P;

    counter_event_collector_if bus_if ();

    counter_event_collector dut (
        .sysclk        (sysclk),
        .foo_card_n    (foo_card_n),
        .cwm_in        (cwm_in),
        .zz1pb_out     (zz1pb_out),
        .debct_pull    (debct_pull),
        .wdfilecardA2P (wdfilecardA2P),
        .bus           (bus_if)
    );

    always #5 sysclk = ~sysclk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  cwm;
        logic        pull;
        logic        wdf;
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        ready;
        logic [4:0]  exp_zz;
        logic        exp_valid;
        logic [2:0]  exp_id;
        logic        exp_irq;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [22];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s: 0x%08h", name, act);
        end else begin
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.reg_wr    = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        tick();
        bus_if.reg_wr    = 1'b0;
    endtask

    task automatic do_rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.reg_rd   = 1'b1;
        bus_if.reg_addr = a;
        tick();
        bus_if.reg_rd   = 1'b0;
        d = bus_if.reg_rdata;
    endtask

    initial begin
        logic [31:0] rv;
        logic [2:0]  drain_ids [9];

        // cwm pull wdf wr rd addr wdata ready | zz valid id irq chk rdata
        vecs[0]  = '{5'b00100, 0, 0, 0, 0, 2'd0, 32'h0,        0, 5'b11011, 0, 3'd0, 0, 0, 32'h0};
        vecs[1]  = '{5'b00100, 0, 0, 0, 0, 2'd0, 32'h0,        0, 5'b11011, 1, 3'd2, 0, 0, 32'h0};
        vecs[2]  = '{5'b00000, 0, 0, 0, 0, 2'd0, 32'h0,        0, 5'b11111, 1, 3'd2, 0, 0, 32'h0};
        vecs[3]  = '{5'b00000, 0, 0, 0, 1, 2'd0, 32'h0,        0, 5'b11111, 1, 3'd2, 0, 1, 32'h004};
        vecs[4]  = '{5'b00000, 0, 0, 0, 1, 2'd2, 32'h0,        1, 5'b11111, 0, 3'd0, 0, 1, 32'h1};
        vecs[5]  = '{5'b00000, 0, 0, 1, 0, 2'd1, 32'h020,      1, 5'b11111, 0, 3'd0, 0, 0, 32'h0};
        vecs[6]  = '{5'b00000, 1, 0, 1, 0, 2'd0, 32'h020,      0, 5'b11111, 0, 3'd0, 0, 0, 32'h0};
        vecs[7]  = '{5'b00000, 0, 0, 0, 1, 2'd0, 32'h0,        0, 5'b11111, 1, 3'd5, 1, 1, 32'h024};
        vecs[8]  = '{5'b00000, 0, 0, 1, 0, 2'd0, 32'h020,      0, 5'b11111, 1, 3'd5, 1, 0, 32'h0};
        vecs[9]  = '{5'b00000, 0, 0, 0, 0, 2'd0, 32'h0,        0, 5'b11111, 1, 3'd5, 0, 0, 32'h0};
        vecs[10] = '{5'b00000, 0, 0, 0, 0, 2'd0, 32'h0,        1, 5'b11111, 0, 3'd0, 0, 0, 32'h0};
        vecs[11] = '{5'b00000, 0, 0, 0, 1, 2'd1, 32'h0,        0, 5'b11111, 0, 3'd0, 0, 1, 32'h020};
        vecs[12] = '{5'b00000, 0, 0, 1, 1, 2'd1, 32'hFFFFFFFF, 0, 5'b11111, 0, 3'd0, 0, 1, 32'h020};
        vecs[13] = '{5'b00000, 0, 0, 0, 1, 2'd1, 32'h0,        0, 5'b11111, 0, 3'd0, 1, 1, 32'h1FFF};
        vecs[14] = '{5'b00000, 0, 0, 1, 0, 2'd0, 32'hFFFFFFFF, 0, 5'b11111, 0, 3'd0, 1, 0, 32'h0};
        vecs[15] = '{5'b00000, 0, 0, 0, 1, 2'd2, 32'h0,        0, 5'b11111, 0, 3'd0, 0, 1, 32'h2};
        vecs[16] = '{5'b00000, 0, 0, 1, 1, 2'd2, 32'h0,        0, 5'b11111, 0, 3'd0, 0, 1, 32'h2};
        vecs[17] = '{5'b00000, 0, 0, 0, 1, 2'd2, 32'h0,        0, 5'b11111, 0, 3'd0, 0, 1, 32'h0};
        vecs[18] = '{5'b00000, 0, 1, 1, 0, 2'd1, 32'h0,        0, 5'b11111, 0, 3'd0, 0, 0, 32'h0};
        vecs[19] = '{5'b00000, 0, 0, 0, 1, 2'd3, 32'h0,        0, 5'b11111, 1, 3'd6, 0, 1, 32'h00004000};
        vecs[20] = '{5'b00000, 0, 0, 0, 1, 2'd3, 32'h0,        0, 5'b11111, 1, 3'd6, 0, 1, 32'h00010000};
        vecs[21] = '{5'b00000, 0, 0, 0, 0, 2'd0, 32'h0,        1, 5'b11111, 0, 3'd0, 0, 0, 32'h0};

        foo_card_n       = 1'b0;
        cwm_in           = '0;
        debct_pull       = 1'b0;
        wdfilecardA2P    = 1'b0;
        bus_if.reg_wr    = 1'b0;
        bus_if.reg_rd    = 1'b0;
        bus_if.reg_addr  = '0;
        bus_if.reg_wdata = '0;
        bus_if.ev_ready  = 1'b0;

        // Initial reset
        tick();
        tick();
        chk("reset_zz", 32'(zz1pb_out), 32'h1F);
        chk("reset_irq", 32'(bus_if.irq), 32'h0);
        chk("reset_valid", 32'(bus_if.ev_valid), 32'h0);
        chk("reset_id", 32'(bus_if.ev_id), 32'h0);
        chk("reset_rdata", bus_if.reg_rdata, 32'h0);
        foo_card_n = 1'b1;
        tick();

        // Table: single ack, W1C race, mask, EVCNT, DBG
        for (int i = 0; i < 22; i++) begin
            cwm_in           = vecs[i].cwm;
            debct_pull       = vecs[i].pull;
            wdfilecardA2P    = vecs[i].wdf;
            bus_if.reg_wr    = vecs[i].wr;
            bus_if.reg_rd    = vecs[i].rd;
            bus_if.reg_addr  = vecs[i].addr;
            bus_if.reg_wdata = vecs[i].wdata;
            bus_if.ev_ready  = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_zz", i), 32'(zz1pb_out), 32'(vecs[i].exp_zz));
            chk($sformatf("vec%0d_valid", i), 32'(bus_if.ev_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_id", i), 32'(bus_if.ev_id), 32'(vecs[i].exp_id));
            chk($sformatf("vec%0d_irq", i), 32'(bus_if.irq), 32'(vecs[i].exp_irq));
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), bus_if.reg_rdata, vecs[i].exp_rdata);
        end
        cwm_in = '0; debct_pull = 0; wdfilecardA2P = 0;
        bus_if.reg_wr = 0; bus_if.reg_rd = 0; bus_if.ev_ready = 0;

        // Timeout: cwm_in[0] held high
        do_wr(2'd0, 32'h1FFF);
        cwm_in = 5'b00001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("tmo_ack_cyc%0d", k), 32'(zz1pb_out[0]), 32'h0);
        end
        tick();
        chk("tmo_wait_zz", 32'(zz1pb_out[0]), 32'h1);
        bus_if.reg_rd = 1'b1; bus_if.reg_addr = 2'd0;
        tick();
        bus_if.reg_rd = 1'b0;
        chk("tmo_status", bus_if.reg_rdata, 32'h101);
        chk("tmo_idle_zz", 32'(zz1pb_out[0]), 32'h1);
        tick();
        chk("tmo_retrigger_zz", 32'(zz1pb_out[0]), 32'h0);
        cwm_in = 5'b00000;
        tick();
        tick();
        do_rd(2'd3, rv);
        chk("tmo_dbg", rv, 32'h00020000);
        do_rd(2'd0, rv);
        chk("tmo_status_noovf", rv, 32'h101);
        bus_if.ev_ready = 1'b1;
        chk("tmo_head0_valid", 32'(bus_if.ev_valid), 32'h1);
        chk("tmo_head0_id", 32'(bus_if.ev_id), 32'h0);
        tick();
        chk("tmo_head1_valid", 32'(bus_if.ev_valid), 32'h1);
        chk("tmo_head1_id", 32'(bus_if.ev_id), 32'h0);
        tick();
        chk("tmo_drained", 32'(bus_if.ev_valid), 32'h0);
        bus_if.ev_ready = 1'b0;

        // Simultaneous events with backpressure, then fill and overflow
        do_wr(2'd0, 32'h1FFF);
        cwm_in = 5'b11111; debct_pull = 1'b1;
        tick();
        chk("bp_all_ack", 32'(zz1pb_out), 32'h00);
        chk("bp_not_yet_valid", 32'(bus_if.ev_valid), 32'h0);
        cwm_in = 5'b00000; debct_pull = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("bp_push%0d_valid", k), 32'(bus_if.ev_valid), 32'h1);
            chk($sformatf("bp_push%0d_head", k), 32'(bus_if.ev_id), 32'h0);
        end
        do_rd(2'd3, rv);
        chk("bp_dbg_level6", rv, 32'h00060000);
        wdfilecardA2P = 1'b1;
        tick();
        wdfilecardA2P = 1'b0; debct_pull = 1'b1;
        tick();
        debct_pull = 1'b0;
        tick();
        tick();
        debct_pull = 1'b1;
        tick();
        tick();
        debct_pull = 1'b0;
        do_rd(2'd3, rv);
        chk("bp_dbg_full_pending", rv, 32'h00082000);
        do_rd(2'd0, rv);
        chk("bp_status_ovf", rv, 32'h0FF);
        drain_ids = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd5};
        bus_if.ev_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("bp_drain%0d_valid", k), 32'(bus_if.ev_valid), 32'h1);
            chk($sformatf("bp_drain%0d_id", k), 32'(bus_if.ev_id), 32'(drain_ids[k]));
            tick();
        end
        chk("bp_drained", 32'(bus_if.ev_valid), 32'h0);
        bus_if.ev_ready = 1'b0;

        // Reset mid-handshake with all flags high
        do_wr(2'd1, 32'h1FFF);
        tick();
        chk("pre_reset_irq", 32'(bus_if.irq), 32'h1);
        cwm_in = 5'b00010;
        tick();
        chk("pre_reset_ack1", 32'(zz1pb_out), 32'h1D);
        foo_card_n = 1'b0; cwm_in = 5'b11111;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("rst%0d_zz", k), 32'(zz1pb_out), 32'h1F);
            chk($sformatf("rst%0d_irq", k), 32'(bus_if.irq), 32'h0);
            chk($sformatf("rst%0d_valid", k), 32'(bus_if.ev_valid), 32'h0);
            chk($sformatf("rst%0d_rdata", k), bus_if.reg_rdata, 32'h0);
        end
        foo_card_n = 1'b1;
        tick();
        chk("post_reset_all_ack", 32'(zz1pb_out), 32'h00);
        cwm_in = 5'b00000;
        do_rd(2'd0, rv);
        chk("post_reset_status", rv, 32'h01F);
        chk("post_reset_irq", 32'(bus_if.irq), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
